des_stream_ctrl: RTL and testbench
==================================

DES_STREAM_CTRL -- requirements
Module: des_stream_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles to wait for core_done before aborting a block.
REQ-002 Parameter CNT_W, default 16: width of the processed-block counter.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cfg_load  in  1  one-cycle pulse; captures cfg_key, cfg_iv, cfg_cbc, cfg_dec.
REQ-006 cfg_key  in  64  DES key.
REQ-007 cfg_iv  in  64  CBC initial vector.
REQ-008 cfg_cbc  in  1  1 = CBC chaining; 0 = ECB.
REQ-009 cfg_dec  in  1  1 = attached core decrypts; 0 = encrypts (selects chaining direction).
REQ-010 in_valid / in_ready / in_data  in / out / 64  input block stream (valid/ready).
REQ-011 out_valid / out_ready / out_data  out / in / 64  output block stream (valid/ready).
REQ-012 core_message  out  64  block to the DES core, registered.
REQ-013 core_key  out  64  key to the DES core, registered.
REQ-014 core_enable  out  1  start strobe to the core.
REQ-015 core_ack  out  1  one-cycle acknowledge to the core.
REQ-016 core_done / core_result  in / in  1 / 64  core completion flag and result block.
REQ-017 busy  out  1  high whenever the state is not IDLE.
REQ-018 timeout_err  out  1  sticky; set on watchdog expiry; cleared by cfg_load.
REQ-019 block_count  out  CNT_W  number of blocks delivered on the output; wraps modulo 2^CNT_W; cleared by cfg_load.

Function
REQ-020 FSM states: IDLE, START, WAIT, ACK, OUT.
REQ-021 IDLE: in_ready=1; on in_valid&in_ready, register the block into core_message and go to START.
REQ-022 Block register: ECB or cfg_dec=1 -> core_message=in_data; CBC with cfg_dec=0 -> core_message=in_data XOR chain.
REQ-023 START: core_enable=1 for exactly one cycle, then go to WAIT; a watchdog counter of ceil(log2(TIMEOUT_CYCLES+1)) bits is zeroed.
REQ-024 WAIT: core_enable=0; on core_done=1, capture out_data and go to ACK.
REQ-025 Output capture: ECB -> core_result; CBC decrypt -> core_result XOR chain, then chain=held input block; CBC encrypt -> core_result, then chain=core_result.
REQ-026 WAIT watchdog: if core_done is not seen within TIMEOUT_CYCLES cycles, set timeout_err, pulse core_ack, and return to IDLE; the block is dropped and chain is unchanged.
REQ-027 ACK: core_ack=1 for exactly one cycle, then go to OUT.
REQ-028 OUT: out_valid=1 with out_data stable until out_ready=1; on handshake, block_count++ and go to IDLE.
REQ-029 Throughput: at most one block in flight; in_ready=0 in every state except IDLE.
REQ-030 core_key and core_message are held constant from START until leaving ACK.
REQ-031 cfg_load in IDLE: capture the configuration; chain=cfg_iv; clear timeout_err and block_count.
REQ-032 cfg_load when not IDLE: ignored entirely.
REQ-033 cfg_load and in_valid in the same IDLE cycle: the configuration is applied first and the block uses the new key and IV.
REQ-034 out_ready held high in OUT: handshake completes in the first OUT cycle; the next input is accepted no earlier than the following cycle.

Reset
REQ-035 Reset returns the FSM to IDLE and clears the following to 0: chain, core_key, core_message, out_data, block_count, timeout_err, watchdog, core_enable, core_ack, out_valid.
REQ-036 Reset asserted mid-operation abandons the in-flight block; no core_ack is issued, and the core is reset by the same reset net.

Structure
REQ-037 A shared package des_pkg holds the FSM state enum, the 64-bit block type, and the TIMEOUT_CYCLES default.
REQ-038 One sub-module, des_cbc_chain, holds the chain register and the XOR-in/XOR-out selection; the FSM and watchdog stay in the top level.

Verification
REQ-039 ECB decrypt: key 133457799BBCDFF1, input 85E813540F0AB405 -> out_data 0123456789ABCDEF; block_count=1.
REQ-040 CBC decrypt, IV 0000000000000001, two blocks -> each output = D(C_i) XOR previous ciphertext (IV for the first block); the chain holds the last ciphertext.
REQ-041 Backpressure: out_ready=0 for 10 cycles -> out_valid and out_data stay stable, in_ready stays 0, block_count is unchanged until the handshake.
REQ-042 Stuck core (core_done tied 0) with TIMEOUT_CYCLES=8 -> timeout_err=1 and a 1-cycle core_ack after 8 WAIT cycles; back in IDLE with in_ready=1.
REQ-043 cfg_load during WAIT -> core_key is unchanged, the result matches the old key, and block_count is not cleared.
REQ-044 Reset pulsed in OUT -> all outputs return to 0 and the next block after reset processes correctly with chain=0.

Source files
------------

// File: rtl/des_pkg.sv
// des_pkg: shared types and defaults for the DES stream controller
// Contents:
//   state_t          controller FSM states
//   block_t          64-bit DES block
//   TIMEOUT_DEFAULT  default watchdog limit in WAIT cycles
package des_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_ACK, S_OUT} state_t;
  typedef logic [63:0] block_t;
  localparam int TIMEOUT_DEFAULT = 255;
endpackage

// File: rtl/des_cbc_chain.sv
// des_cbc_chain: CBC chain register with the XOR-in / XOR-out selection
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   load_iv        configuration is being loaded this cycle (chain <= cfg_iv)
//   cfg_iv         initial vector
//   cbc, dec       effective mode for this cycle
//   in_data        raw input block
//   core_result    block returned by the core
//   held           block currently presented to the core
//   update         the core result is being captured this cycle
//   msg_nx         block to register into core_message
//   res_nx         block to register into out_data
module des_cbc_chain import des_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_iv,
  input  logic [63:0] cfg_iv,
  input  logic        cbc,
  input  logic        dec,
  input  logic [63:0] in_data,
  input  logic [63:0] core_result,
  input  logic [63:0] held,
  input  logic        update,
  output logic [63:0] msg_nx,
  output logic [63:0] res_nx
);
  block_t chain;
  block_t chain_e;
  // a block accepted in the same cycle as a configuration load chains off the new IV
  assign chain_e = load_iv ? cfg_iv : chain;
  assign msg_nx = cbc && !dec ? in_data ^ chain_e : in_data;
  assign res_nx = cbc && dec ? core_result ^ chain : core_result;
  // decrypt chains on the ciphertext that went in, encrypt on the ciphertext that came out
  always_ff @(posedge clk or posedge reset)
    if (reset) chain <= '0;
    else if (load_iv) chain <= cfg_iv;
    else if (update && cbc) chain <= dec ? held : core_result;
endmodule

// File: rtl/des_stream_ctrl.sv
// des_stream_ctrl: valid/ready block stream wrapper around an external DES core (ECB/CBC)
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   cfg_load, cfg_key, cfg_iv,
//   cfg_cbc, cfg_dec                 configuration capture (honoured only when idle)
//   in_valid, in_ready, in_data      input block stream
//   out_valid, out_ready, out_data   output block stream
//   core_message, core_key           registered block and key to the core
//   core_enable, core_ack            one-cycle start strobe / acknowledge to the core
//   core_done, core_result           core completion and result
//   busy                             controller not idle
//   timeout_err                      sticky watchdog flag, cleared by cfg_load
//   block_count                      delivered block count, cleared by cfg_load
module des_stream_ctrl import des_pkg::*; #(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_load,
  input  logic [63:0]      cfg_key,
  input  logic [63:0]      cfg_iv,
  input  logic             cfg_cbc,
  input  logic             cfg_dec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [63:0]      core_message,
  output logic [63:0]      core_key,
  output logic             core_enable,
  output logic             core_ack,
  input  logic             core_done,
  input  logic [63:0]      core_result,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] block_count
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_nx;
  logic [WD_W-1:0] wd;
  logic cbc_q, dec_q, load, accept, done_cap, expire, deliver;
  block_t msg_nx, res_nx;
  assign load = cfg_load && state == S_IDLE;
  assign accept = in_valid && state == S_IDLE;
  assign done_cap = state == S_WAIT && core_done;
  assign expire = state == S_WAIT && !core_done && wd == WD_W'(TIMEOUT_CYCLES - 1);
  assign deliver = state == S_OUT && out_ready;
  des_cbc_chain u_chain (
    .clk(clk),
    .reset(reset),
    .load_iv(load),
    .cfg_iv(cfg_iv),
    .cbc(load ? cfg_cbc : cbc_q),
    .dec(load ? cfg_dec : dec_q),
    .in_data(in_data),
    .core_result(core_result),
    .held(core_message),
    .update(done_cap),
    .msg_nx(msg_nx),
    .res_nx(res_nx)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = accept ? S_START : S_IDLE;
      S_START: state_nx = S_WAIT;
      S_WAIT:  state_nx = core_done ? S_ACK : expire ? S_IDLE : S_WAIT;
      S_ACK:   state_nx = S_OUT;
      S_OUT:   state_nx = out_ready ? S_IDLE : S_OUT;
      default: state_nx = S_IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == S_IDLE;
    busy = state != S_IDLE;
    out_valid = state == S_OUT;
  end
  // strobes are registered from the next state so they coincide with START/ACK;
  // a watchdog expiry acknowledges the core in the first IDLE cycle instead
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      core_key <= '0;
      core_message <= '0;
      out_data <= '0;
      block_count <= '0;
      timeout_err <= 1'b0;
      wd <= '0;
      core_enable <= 1'b0;
      core_ack <= 1'b0;
      cbc_q <= 1'b0;
      dec_q <= 1'b0;
    end else begin
      core_enable <= state_nx == S_START;
      core_ack <= state_nx == S_ACK || expire;
      if (load) begin
        core_key <= cfg_key;
        cbc_q <= cfg_cbc;
        dec_q <= cfg_dec;
      end
      if (accept) core_message <= msg_nx;
      if (state == S_START) wd <= '0;
      else if (state == S_WAIT) wd <= wd + 1'b1;
      if (done_cap) out_data <= res_nx;
      timeout_err <= !load && (timeout_err || expire);
      block_count <= load ? '0 : block_count + CNT_W'(deliver);
    end
endmodule

// File: tb/tb_des_stream_ctrl.sv
// tb_des_stream_ctrl: randomized and directed checks of des_stream_ctrl against a transaction model
module tb_des_stream_ctrl;
  localparam logic [63:0] DES_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] DES_CT = 64'h85E813540F0AB405;
  localparam logic [63:0] DES_PT = 64'h0123456789ABCDEF;
  logic clk = 1'b0, reset = 1'b1;
  logic cfg_load = 1'b0, cfg_cbc = 1'b0, cfg_dec = 1'b0, in_valid = 1'b0, out_ready = 1'b0, core_done = 1'b0;
  logic [63:0] cfg_key = '0, cfg_iv = '0, in_data = '0, core_result = '0;
  logic in_ready, out_valid, core_enable, core_ack, busy, timeout_err;
  logic [63:0] out_data, core_message, core_key;
  logic [15:0] block_count;
  int n_tests = 0, n_fail = 0;
  int stuck = 0, lat_fix = 0;
  des_stream_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .cfg_cbc(cfg_cbc), .cfg_dec(cfg_dec), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_message(core_message), .core_key(core_key), .core_enable(core_enable),
    .core_ack(core_ack), .core_done(core_done), .core_result(core_result), .busy(busy),
    .timeout_err(timeout_err), .block_count(block_count)
  );
  always #5 clk = ~clk;
  // stand-in DES core: the known test vector decrypts correctly, anything else is a fixed scramble
  function automatic logic [63:0] core_f(input logic [63:0] k, input logic [63:0] m);
    return (k == DES_KEY && m == DES_CT) ? DES_PT : {m[31:0], m[63:32]} ^ k ^ 64'h5A5AC3C30F0F9696;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic fail_msg(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: expected event did not occur within its cycle budget at %0t", nm, $time);
  endtask
  int ccnt = 0;
  logic [63:0] hkey, hmsg;
  always @(negedge clk or posedge reset)
    if (reset) begin
      ccnt = 0;
      core_done = 1'b0;
    end else begin
      core_done = 1'b0;
      if (ccnt > 0) begin
        ccnt--;
        if (ccnt == 0) begin
          core_done = 1'b1;
          core_result = core_f(hkey, hmsg);
        end
      end
      if (core_enable && stuck == 0) begin
        ccnt = lat_fix != 0 ? lat_fix : int'($urandom_range(1, 6));
        hkey = core_key;
        hmsg = core_message;
      end
    end
  logic [63:0] key_m, chain_m;
  logic cbc_m, dec_m, terr_m;
  logic [15:0] cnt_m;
  logic [63:0] q[$];
  function automatic logic [63:0] exp_msg(input logic [63:0] x);
    return (cbc_m && !dec_m) ? x ^ chain_m : x;
  endfunction
  function automatic logic [63:0] exp_out(input logic [63:0] x);
    return !cbc_m ? core_f(key_m, x) : dec_m ? core_f(key_m, x) ^ chain_m : core_f(key_m, x ^ chain_m);
  endfunction
  always @(negedge clk)
    if (reset) begin
      q.delete();
      key_m = '0;
      chain_m = '0;
      cbc_m = 1'b0;
      dec_m = 1'b0;
      terr_m = 1'b0;
      cnt_m = '0;
    end else begin
      if (core_ack && in_ready) begin
        if (q.size() == 0) fail_msg("ack_without_block");
        else void'(q.pop_front());
        terr_m = 1'b1;
      end
      chk("in_ready", in_ready, q.size() == 0);
      chk("busy", busy, q.size() != 0);
      chk("block_count", block_count, cnt_m);
      chk("timeout_err", timeout_err, terr_m);
      if (q.size() != 0) begin
        chk("core_key", core_key, key_m);
        chk("core_message", core_message, exp_msg(q[0]));
        if (out_valid) chk("out_data", out_data, exp_out(q[0]));
      end else if (out_valid) fail_msg("out_valid_without_block");
      if (cfg_load && in_ready) begin
        key_m = cfg_key;
        chain_m = cfg_iv;
        cbc_m = cfg_cbc;
        dec_m = cfg_dec;
        cnt_m = '0;
        terr_m = 1'b0;
      end
      if (in_valid && in_ready) q.push_back(in_data);
      if (out_valid && out_ready && q.size() != 0) begin
        if (cbc_m) chain_m = dec_m ? q[0] : core_f(key_m, q[0] ^ chain_m);
        void'(q.pop_front());
        cnt_m++;
      end
    end
  task automatic do_cfg(input logic [63:0] k, input logic [63:0] iv, input logic cbc, input logic dec);
    @(posedge clk);
    #1;
    cfg_key = k;
    cfg_iv = iv;
    cfg_cbc = cbc;
    cfg_dec = dec;
    cfg_load = 1'b1;
    @(posedge clk);
    #1 cfg_load = 1'b0;
  endtask
  task automatic send(input logic [63:0] x);
    int t = 0;
    in_data = x;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 100);
    if (!in_ready) fail_msg("send_accept");
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic wait_ev(input string nm, input int which);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(which == 0 ? out_valid : which == 1 ? core_enable : in_ready) && t < 200);
    if (t >= 200) fail_msg(nm);
  endtask
  task automatic get_out(output logic [63:0] d);
    out_ready = 1'b1;
    wait_ev("wait_out_valid", 0);
    d = out_data;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [63:0] d, x;
    int n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_core_message", core_message, 0);
    chk("rst_count", block_count, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_enable_ack", {core_enable, core_ack}, 0);
    do_cfg(DES_KEY, 64'h0, 1'b0, 1'b1);
    send(DES_CT);
    get_out(d);
    chk("ecb_dec_data", d, DES_PT);
    chk("ecb_dec_count", block_count, 1);
    do_cfg(DES_KEY, 64'h1, 1'b1, 1'b1);
    send(DES_CT);
    get_out(d);
    chk("cbc_dec_blk1", d, 64'h0123456789ABCDEE);
    send(DES_CT);
    get_out(d);
    chk("cbc_dec_blk2", d, 64'h84CB563386A179EA);
    send(DES_CT);
    get_out(d);
    chk("cbc_dec_blk3", d, 64'h84CB563386A179EA);
    chk("cbc_dec_count", block_count, 3);
    out_ready = 1'b0;
    send({$urandom, $urandom});
    wait_ev("bp_out_valid", 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_count", block_count, 3);
    end
    @(posedge clk);
    #1;
    get_out(d);
    chk("bp_count_after", block_count, 4);
    do_cfg(DES_KEY, 64'h0, 1'b0, 1'b1);
    lat_fix = 5;
    send(DES_CT);
    wait_ev("wait_enable", 1);
    @(posedge clk);
    #1;
    cfg_key = {$urandom, $urandom};
    cfg_cbc = 1'b1;
    cfg_load = 1'b1;
    @(posedge clk);
    #1 cfg_load = 1'b0;
    get_out(d);
    chk("busy_cfg_data", d, DES_PT);
    chk("busy_cfg_key", core_key, DES_KEY);
    chk("busy_cfg_count", block_count, 1);
    lat_fix = 0;
    stuck = 1;
    send({$urandom, $urandom});
    wait_ev("stuck_enable", 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!core_ack && n < 50);
    chk("timeout_latency", n, 9);
    chk("timeout_flag", timeout_err, 1);
    chk("timeout_in_ready", in_ready, 1);
    @(negedge clk);
    chk("timeout_ack_width", core_ack, 0);
    chk("timeout_count", block_count, 1);
    stuck = 0;
    do_cfg({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
    chk("cfg_clears_timeout", timeout_err, 0);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      in_valid = $urandom_range(0, 2) != 0;
      in_data = {$urandom, $urandom};
      out_ready = $urandom_range(0, 3) != 0;
      cfg_load = $urandom_range(0, 60) == 0;
      cfg_key = {$urandom, $urandom};
      cfg_iv = {$urandom, $urandom};
      cfg_cbc = 1'($urandom);
      cfg_dec = 1'($urandom);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_load = 1'b0;
    out_ready = 1'b1;
    wait_ev("drain", 2);
    @(posedge clk);
    #1 out_ready = 1'b0;
    send({$urandom, $urandom});
    wait_ev("rst_out_valid_wait", 0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_count", block_count, 0);
    chk("midrst_core_key", core_key, 0);
    chk("midrst_core_message", core_message, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_ack", core_ack, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    x = {$urandom, $urandom};
    send(x);
    get_out(d);
    chk("post_reset_data", d, core_f(64'h0, x));
    chk("post_reset_count", block_count, 1);
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
